// File: rtl/rob_pkg.sv
// Shared ROB definitions: unique-ID width helpers and the tag/beat types used by
// both the AR-side allocator and the R-side reorder buffer.
package rob_pkg;

    localparam int DEF_NUM_ROWS   = 4;
    localparam int DEF_NUM_COLS   = 4;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_RESP_WIDTH = 2;

    function automatic int row_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    function automatic int col_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

    function automatic int uid_w(input int num_rows, input int num_cols);
        return row_w(num_rows) + col_w(num_cols);
    endfunction

    localparam int DEF_ROW_W = row_w(DEF_NUM_ROWS);
    localparam int DEF_COL_W = col_w(DEF_NUM_COLS);
    localparam int DEF_UID_W = DEF_ROW_W + DEF_COL_W;

    // Row sits in the MSBs so a uid doubles as a flat slot index.
    typedef struct packed {
        logic [DEF_ROW_W-1:0] row;
        logic [DEF_COL_W-1:0] col;
    } uid_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_RESP_WIDTH-1:0] resp;
    } r_beat_t;

endpackage

// File: rtl/rr_row_arbiter.sv
// Round-robin pick of the first eligible row at or after rr_ptr, wrapping.
module rr_row_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int ROW_W    = 2
) (
    input  logic [NUM_ROWS-1:0] eligible,
    input  logic [ROW_W-1:0]    rr_ptr,
    output logic                grant_valid,
    output logic [ROW_W-1:0]    grant_row
);

    logic [ROW_W-1:0] cand;

    // Walk offsets from far to near so the closest eligible row wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_row   = '0;
        cand        = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            cand = rr_ptr + ROW_W'(i);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_row   = cand;
            end
        end
    end

endmodule

// File: rtl/r_reorder_buffer.sv
// R-path reorder buffer: parks beats by unique ID and releases them upstream in
// per-row issue order, returning each tag to the allocator as it goes out.
module r_reorder_buffer
    import rob_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RESP_WIDTH = DEF_RESP_WIDTH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    localparam int ROW_W     = row_w(NUM_ROWS),
    localparam int COL_W     = col_w(NUM_COLS),
    localparam int UID_W     = ROW_W + COL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [UID_W-1:0]      s_rid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [RESP_WIDTH-1:0] s_rresp,
    input  logic                  s_rlast,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    output logic [ID_WIDTH-1:0]   m_rid,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic [RESP_WIDTH-1:0] m_rresp,
    output logic                  m_rlast,
    output logic                  free_req,
    output logic [UID_W-1:0]      free_unique_id,
    input  logic [ID_WIDTH-1:0]   restored_id,
    output logic                  err_multibeat
);

    localparam int NUM_SLOTS = NUM_ROWS * NUM_COLS;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
    } beat_t;

    logic [NUM_SLOTS-1:0] slot_valid;
    beat_t                slot_mem [NUM_SLOTS];
    logic [COL_W-1:0]     exp_col  [NUM_ROWS];
    logic [ROW_W-1:0]     rr_ptr;
    logic [NUM_ROWS-1:0]  eligible;
    logic                 grant_valid;
    logic [ROW_W-1:0]     grant_row;
    logic [UID_W-1:0]     head_uid;
    logic                 s_fire;
    logic                 load;

    always_comb begin
        eligible = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            eligible[r] = slot_valid[{ROW_W'(r), exp_col[r]}];
        end
    end

    rr_row_arbiter #(
        .NUM_ROWS (NUM_ROWS),
        .ROW_W    (ROW_W)
    ) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_row   (grant_row)
    );

    // A slot still draining this cycle reads as occupied, so ingress and release
    // can never target the same slot in one cycle.
    assign s_rready       = ~slot_valid[s_rid];
    assign s_fire         = s_rvalid & s_rready;
    assign head_uid       = {grant_row, exp_col[grant_row]};
    assign load           = (~m_rvalid | m_rready) & grant_valid;
    assign free_req       = load;
    assign free_unique_id = load ? head_uid : '0;

    always_ff @(posedge clk) begin
        if (s_fire) begin
            slot_mem[s_rid] <= '{data: s_rdata, resp: s_rresp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid    <= '0;
            rr_ptr        <= '0;
            m_rvalid      <= 1'b0;
            m_rid         <= '0;
            m_rdata       <= '0;
            m_rresp       <= '0;
            m_rlast       <= 1'b0;
            err_multibeat <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                exp_col[r] <= '0;
            end
        end else begin
            err_multibeat <= s_fire & ~s_rlast;
            if (s_fire) begin
                slot_valid[s_rid] <= 1'b1;
            end
            if (load) begin
                slot_valid[head_uid] <= 1'b0;
                exp_col[grant_row]   <= exp_col[grant_row] + COL_W'(1);
                rr_ptr               <= grant_row + ROW_W'(1);
                m_rvalid             <= 1'b1;
                m_rid                <= restored_id;
                m_rdata              <= slot_mem[head_uid].data;
                m_rresp              <= slot_mem[head_uid].resp;
                m_rlast              <= 1'b1;
            end else if (m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_r_reorder_buffer.sv
// Scenario bench for r_reorder_buffer: directed cases plus randomized batches
// checked against per-row issue-order expectations.
module tb_r_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        s_rvalid;
    logic        s_rready;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [3:0]  m_rid;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        free_req;
    logic [3:0]  free_unique_id;
    logic [3:0]  restored_id;
    logic        err_multibeat;

    logic [3:0]  id_tab [16];

    r_reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .s_rvalid       (s_rvalid),
        .s_rready       (s_rready),
        .s_rid          (s_rid),
        .s_rdata        (s_rdata),
        .s_rresp        (s_rresp),
        .s_rlast        (s_rlast),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .m_rid          (m_rid),
        .m_rdata        (m_rdata),
        .m_rresp        (m_rresp),
        .m_rlast        (m_rlast),
        .free_req       (free_req),
        .free_unique_id (free_unique_id),
        .restored_id    (restored_id),
        .err_multibeat  (err_multibeat)
    );

    // Allocator stand-in: the original ID of each tag is whatever the bench stored.
    assign restored_id = id_tab[free_unique_id];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] uid;
    } free_ev_t;

    typedef struct {
        int          cyc;
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } out_ev_t;

    free_ev_t free_log[$];
    out_ev_t  out_log[$];
    int       err_log[$];
    int       cyc;
    int       total;
    int       bad;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        free_ev_t fe;
        out_ev_t  oe;
        if (free_req) begin
            fe.cyc = cyc;
            fe.uid = free_unique_id;
            free_log.push_back(fe);
        end
        if (m_rvalid && m_rready) begin
            oe.cyc  = cyc;
            oe.id   = m_rid;
            oe.data = m_rdata;
            oe.resp = m_rresp;
            oe.last = m_rlast;
            out_log.push_back(oe);
        end
        if (err_multibeat) err_log.push_back(cyc);
    end

    task automatic clear_logs();
        free_log.delete();
        out_log.delete();
        err_log.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_rvalid = 1'b0;
        s_rlast  = 1'b1;
        m_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [3:0] uid, input logic [63:0] d, input logic [1:0] r,
                        input logic last, output int acc_cyc);
        s_rvalid = 1'b1;
        s_rid    = uid;
        s_rdata  = d;
        s_rresp  = r;
        s_rlast  = last;
        acc_cyc  = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_rready) begin
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        s_rlast  = 1'b1;
        if (acc_cyc < 0) begin
            total++; bad++;
            $display("FAIL send_timeout uid=%0h got s_rready=0 for 100 cycles need 1", uid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rvalid = 1'b0; s_rid = 4'h3; s_rdata = '0; s_rresp = '0;
        s_rlast = 1'b1; m_rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, free_req, err_multibeat} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%0b id=%0h d=%0h r=%0h l=%0b f=%0b e=%0b need all 0",
                     m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, free_req, err_multibeat);
        end
        total++;
        if (s_rready !== 1'b1) begin
            bad++; $display("FAIL reset_s_rready got %0b need 1", s_rready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_in_order();
        logic [63:0] d [2];
        int a;
        d[0] = 64'h1111_0000_aaaa_0001;
        d[1] = 64'h2222_0000_bbbb_0002;
        do_reset();
        id_tab[0] = 4'h5; id_tab[1] = 4'h5;
        m_rready = 1'b1;
        send(4'h0, d[0], 2'b00, 1'b1, a);
        send(4'h1, d[1], 2'b01, 1'b1, a);
        wait_cycles(5);
        total++;
        if (out_log.size() != 2 || free_log.size() != 2) begin
            bad++;
            $display("FAIL inorder_count got out=%0d free=%0d need 2/2", out_log.size(), free_log.size());
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_log[i].id !== 4'h5 || out_log[i].data !== d[i] || out_log[i].last !== 1'b1
                || free_log[i].uid !== 4'(i)) begin
                bad++;
                $display("FAIL inorder_beat%0d got id=%0h d=%0h last=%0b uid=%0h need id=5 d=%0h last=1 uid=%0h",
                         i, out_log[i].id, out_log[i].data, out_log[i].last, free_log[i].uid, d[i], i);
            end
        end
    endtask

    task automatic test_out_of_order();
        logic [63:0] da, db;
        int a;
        da = 64'hAAAA_AAAA_0000_0011;
        db = 64'hBBBB_BBBB_0000_0010;
        do_reset();
        id_tab[4] = 4'h9; id_tab[5] = 4'h9;
        m_rready = 1'b1;
        send(4'h5, da, 2'b00, 1'b1, a);
        wait_cycles(3);
        total++;
        if (out_log.size() != 0 || free_log.size() != 0) begin
            bad++;
            $display("FAIL ooo_hold got out=%0d free=%0d need 0/0", out_log.size(), free_log.size());
        end
        send(4'h4, db, 2'b00, 1'b1, a);
        wait_cycles(5);
        total++;
        if (out_log.size() != 2 || out_log[0].data !== db || out_log[1].data !== da) begin
            bad++;
            $display("FAIL ooo_order got n=%0d d0=%0h d1=%0h need 2 %0h %0h",
                     out_log.size(), out_log[0].data, out_log[1].data, db, da);
        end
        total++;
        if (out_log[0].cyc != a + 2 || out_log[1].cyc != out_log[0].cyc + 1) begin
            bad++;
            $display("FAIL ooo_timing got c0=%0d c1=%0d need %0d %0d",
                     out_log[0].cyc, out_log[1].cyc, a + 2, a + 3);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_uid [4];
        logic [63:0] dv [16];
        int a;
        exp_uid[0] = 4'h0; exp_uid[1] = 4'h8; exp_uid[2] = 4'hC; exp_uid[3] = 4'h1;
        for (int i = 0; i < 16; i++) begin
            dv[i] = {$urandom, $urandom};
            id_tab[i] = 4'(i + 3);
        end
        do_reset();
        send(4'h0, dv[0], 2'b00, 1'b1, a);
        wait_cycles(2);
        send(4'h1, dv[1], 2'b00, 1'b1, a);
        send(4'h8, dv[8], 2'b00, 1'b1, a);
        send(4'hC, dv[12], 2'b00, 1'b1, a);
        wait_cycles(2);
        m_rready = 1'b1;
        wait_cycles(8);
        total++;
        if (free_log.size() != 4 || out_log.size() != 4) begin
            bad++;
            $display("FAIL rr_count got free=%0d out=%0d need 4/4", free_log.size(), out_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (free_log[i].uid !== exp_uid[i] || out_log[i].data !== dv[exp_uid[i]]
                || out_log[i].id !== id_tab[exp_uid[i]]) begin
                bad++;
                $display("FAIL rr_order%0d got uid=%0h d=%0h id=%0h need uid=%0h d=%0h id=%0h", i,
                         free_log[i].uid, out_log[i].data, out_log[i].id,
                         exp_uid[i], dv[exp_uid[i]], id_tab[exp_uid[i]]);
            end
        end
    endtask

    task automatic test_backpressure_wrap();
        logic [63:0] d [5];
        logic [3:0]  exp_uid [5];
        logic [63:0] snap_d;
        logic [3:0]  snap_id;
        int a;
        for (int i = 0; i < 5; i++) begin
            d[i] = {32'hC0DE_0000 + i, $urandom};
            exp_uid[i] = 4'(i % 4);
        end
        for (int i = 0; i < 4; i++) id_tab[i] = 4'(8 + i);
        do_reset();
        send(4'h0, d[0], 2'b00, 1'b1, a);
        send(4'h1, d[1], 2'b00, 1'b1, a);
        wait_cycles(2);
        snap_d = m_rdata; snap_id = m_rid;
        total++;
        if (m_rvalid !== 1'b1 || snap_d !== d[0] || snap_id !== 4'h8) begin
            bad++;
            $display("FAIL bp_first got v=%0b d=%0h id=%0h need 1 %0h 8", m_rvalid, snap_d, snap_id, d[0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (m_rvalid !== 1'b1 || m_rdata !== snap_d || m_rid !== snap_id || free_req !== 1'b0) begin
                bad++;
                $display("FAIL bp_stable%0d got v=%0b d=%0h id=%0h f=%0b need 1 %0h %0h 0",
                         i, m_rvalid, m_rdata, m_rid, free_req, snap_d, snap_id);
            end
        end
        @(posedge clk); #1;
        m_rready = 1'b1;
        send(4'h2, d[2], 2'b00, 1'b1, a);
        send(4'h3, d[3], 2'b00, 1'b1, a);
        send(4'h0, d[4], 2'b11, 1'b1, a);
        wait_cycles(6);
        total++;
        if (free_log.size() != 5 || out_log.size() != 5) begin
            bad++;
            $display("FAIL wrap_count got free=%0d out=%0d need 5/5", free_log.size(), out_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (free_log[i].uid !== exp_uid[i] || out_log[i].data !== d[i]) begin
                bad++;
                $display("FAIL wrap_beat%0d got uid=%0h d=%0h need uid=%0h d=%0h",
                         i, free_log[i].uid, out_log[i].data, exp_uid[i], d[i]);
            end
        end
    endtask

    task automatic test_duplicate();
        logic [63:0] da, db, dc;
        int a, acc_dup;
        da = 64'hD0D0_0000_0000_0021;
        db = 64'hD0D0_0000_0000_0020;
        dc = 64'hD0D0_0000_0000_0121;
        do_reset();
        m_rready = 1'b1;
        send(4'h9, da, 2'b00, 1'b1, a);
        @(posedge clk); #1;
        s_rvalid = 1'b1; s_rid = 4'h9; s_rdata = dc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (s_rready !== 1'b0) begin
                bad++; $display("FAIL dup_stall%0d got s_rready=%0b need 0", i, s_rready);
            end
        end
        @(posedge clk); #1;
        s_rvalid = 1'b0;
        send(4'h8, db, 2'b00, 1'b1, a);
        send(4'h9, dc, 2'b00, 1'b1, acc_dup);
        wait_cycles(5);
        total++;
        if (free_log.size() != 2 || free_log[0].uid !== 4'h8 || free_log[1].uid !== 4'h9
            || out_log[0].data !== db || out_log[1].data !== da) begin
            bad++;
            $display("FAIL dup_release got n=%0d u0=%0h u1=%0h d0=%0h d1=%0h need 2 8 9 %0h %0h",
                     free_log.size(), free_log[0].uid, free_log[1].uid, out_log[0].data,
                     out_log[1].data, db, da);
        end
        total++;
        if (acc_dup != free_log[1].cyc + 1) begin
            bad++;
            $display("FAIL dup_accept got cyc=%0d need %0d", acc_dup, free_log[1].cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] dn;
        int a;
        dn = 64'hFEED_FACE_0000_0001;
        do_reset();
        send(4'h0, 64'h1, 2'b01, 1'b1, a);
        send(4'h1, 64'h2, 2'b01, 1'b1, a);
        send(4'h5, 64'h3, 2'b01, 1'b1, a);
        send(4'h9, 64'h4, 2'b01, 1'b1, a);
        wait_cycles(1);
        total++;
        if (m_rvalid !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got m_rvalid=%0b need 1", m_rvalid);
        end
        clear_logs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, free_req} !== '0 || s_rready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_clear got v=%0b id=%0h d=%0h r=%0h l=%0b f=%0b rdy=%0b need 0s rdy=1",
                     m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, free_req, s_rready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_rready = 1'b1;
        wait_cycles(3);
        total++;
        if (free_log.size() != 0 || out_log.size() != 0) begin
            bad++;
            $display("FAIL rstmid_nofree got free=%0d out=%0d need 0/0", free_log.size(), out_log.size());
        end
        id_tab[0] = 4'h7;
        send(4'h0, dn, 2'b10, 1'b1, a);
        wait_cycles(4);
        total++;
        if (free_log.size() != 1 || out_log.size() != 1 || free_log[0].uid !== 4'h0
            || out_log[0].data !== dn || out_log[0].id !== 4'h7 || out_log[0].resp !== 2'b10) begin
            bad++;
            $display("FAIL rstmid_fresh got nf=%0d no=%0d d=%0h id=%0h r=%0h need 1 1 %0h 7 2",
                     free_log.size(), out_log.size(), out_log[0].data, out_log[0].id,
                     out_log[0].resp, dn);
        end
    endtask

    task automatic test_multibeat();
        logic [63:0] dm;
        int a;
        dm = 64'h0BAD_BEEF_0000_00C0;
        do_reset();
        id_tab[12] = 4'hE;
        m_rready = 1'b1;
        send(4'hC, dm, 2'b10, 1'b0, a);
        wait_cycles(5);
        total++;
        if (err_log.size() != 1 || err_log[0] != a + 1) begin
            bad++;
            $display("FAIL multibeat_err got n=%0d cyc=%0d need 1 %0d", err_log.size(), err_log[0], a + 1);
        end
        total++;
        if (out_log.size() != 1 || out_log[0].data !== dm || out_log[0].resp !== 2'b10
            || out_log[0].id !== 4'hE || out_log[0].last !== 1'b1) begin
            bad++;
            $display("FAIL multibeat_release got n=%0d d=%0h r=%0h id=%0h l=%0b need 1 %0h 2 e 1",
                     out_log.size(), out_log[0].data, out_log[0].resp, out_log[0].id,
                     out_log[0].last, dm);
        end
    endtask

    // Each batch sends every slot once in shuffled order; per row the releases
    // must come out col 0..3 carrying that batch's data.
    task automatic test_random();
        logic [63:0] bdata [16];
        logic [1:0]  bresp [16];
        logic [3:0]  order [16];
        logic [3:0]  tmp;
        int          next_col [4];
        int          a, j, base, waited;
        do_reset();
        for (int i = 0; i < 16; i++) id_tab[i] = 4'($urandom);
        for (int r = 0; r < 4; r++) next_col[r] = 0;
        for (int b = 0; b < 6; b++) begin
            base = out_log.size();
            for (int i = 0; i < 16; i++) begin
                order[i] = 4'(i);
                bdata[i] = {$urandom, $urandom};
                bresp[i] = 2'($urandom);
            end
            for (int i = 15; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            for (int i = 0; i < 16; i++) begin
                m_rready = 1'($urandom_range(0, 1));
                send(order[i], bdata[order[i]], bresp[order[i]], 1'b1, a);
                if ($urandom_range(0, 3) == 0) wait_cycles(1);
            end
            waited = 0;
            while (out_log.size() < base + 16 && waited < 300) begin
                @(posedge clk); #1;
                m_rready = 1'($urandom_range(0, 2) != 0);
                waited++;
            end
            m_rready = 1'b1;
            wait_cycles(3);
            total++;
            if (out_log.size() != base + 16 || free_log.size() != base + 16) begin
                bad++;
                $display("FAIL rand_count batch=%0d got out=%0d free=%0d need %0d",
                         b, out_log.size(), free_log.size(), base + 16);
            end
            for (int i = base; i < base + 16; i++) begin
                int r;
                logic [3:0] u;
                u = free_log[i].uid;
                r = int'(u[3:2]);
                total++;
                if (int'(u[1:0]) != next_col[r] || out_log[i].data !== bdata[u]
                    || out_log[i].resp !== bresp[u] || out_log[i].id !== id_tab[u]
                    || out_log[i].last !== 1'b1) begin
                    bad++;
                    $display("FAIL rand_beat b=%0d i=%0d got uid=%0h d=%0h r=%0h id=%0h need col=%0d d=%0h r=%0h id=%0h",
                             b, i, u, out_log[i].data, out_log[i].resp, out_log[i].id,
                             next_col[r], bdata[u], bresp[u], id_tab[u]);
                end
                next_col[r] = (next_col[r] + 1) % 4;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) id_tab[i] = '0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_round_robin();
        test_backpressure_wrap();
        test_duplicate();
        test_reset_mid();
        test_multibeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
